// File: rtl/ivl_uvm_arb_pkg.sv
// Shared types and width helper for the round-robin arbiter and its bench.
//   arb_state_e : arbiter FSM state encoding (IDLE, GNT, GAP)
//   clog2_min1  : $clog2 clamped to a minimum of 1 so that a 1-entry index still
//                 has a real bit to carry.
package ivl_uvm_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT  = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ivl_uvm_rr_pick.sv
// Combinational rotating-priority picker.
//   req   in  N  request vector
//   ptr   in  W  index of the highest-priority requester
//   found out 1  at least one request is set
//   idx   out W  first set request at or after ptr, wrapping N-1 -> 0
// The request vector is duplicated so that the wrap-around becomes a plain
// search of the upper copy: bits below ptr in the lower copy are masked off,
// and the lowest surviving bit (taken modulo N) is the winner.
module ivl_uvm_rr_pick
    import ivl_uvm_arb_pkg::*;
#(
    parameter int N = 8,
    parameter int W = clog2_min1(N)
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic         found,
    output logic [W-1:0] idx
);

    localparam int DW = 2 * N;

    logic [DW-1:0] dbl;
    logic [DW-1:0] low_mask;
    logic [DW-1:0] masked;

    always_comb begin
        dbl      = {req, req};
        low_mask = (DW'(1) << ptr) - DW'(1);
        masked   = dbl & ~low_mask;
        found    = 1'b0;
        idx      = '0;
        // Scan downward so the last hit written is the lowest set bit.
        for (int i = DW - 1; i >= 0; i--) begin
            if (masked[i]) begin
                found = 1'b1;
                idx   = W'(i % N);
            end
        end
    end

endmodule

// File: rtl/ivl_uvm_rr_arb.sv
// Round-robin arbiter sharing one resource between N requesters.
//   clock      in  1  rising-edge clock
//   reset      in  1  asynchronous active-high reset
//   enable     in  1  permits new grants; an ongoing tenure is unaffected
//   req        in  N  level requests, held until served
//   lock       in  1  lets the current owner exceed MAX_HOLD while its req stays high
//   gnt        out N  registered one-hot grant, or zero
//   gnt_valid  out 1  |gnt
//   gnt_id     out W  index of the owner; keeps the last owner while gnt is zero
// Tenure ends when the owner drops req or after MAX_HOLD cycles (unless locked).
// The released owner moves to lowest priority; GAP_CYCLES idle cycles then
// separate owners, or with GAP_CYCLES==0 the next owner is picked immediately.
module ivl_uvm_rr_arb
    import ivl_uvm_arb_pkg::*;
#(
    parameter int N          = 8,
    parameter int MAX_HOLD   = 4,
    parameter int GAP_CYCLES = 1,
    parameter int W          = clog2_min1(N)
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         enable,
    input  logic [N-1:0] req,
    input  logic         lock,
    output logic [N-1:0] gnt,
    output logic         gnt_valid,
    output logic [W-1:0] gnt_id
);

    localparam int HOLD_W = clog2_min1(MAX_HOLD + 1);
    localparam int GAP_W  = clog2_min1(GAP_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_SAT  = HOLD_W'(MAX_HOLD);
    localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
    localparam logic [GAP_W-1:0]  GAP_LAST  = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

    arb_state_e        state, state_n;
    logic [W-1:0]      ptr, ptr_n;
    logic [HOLD_W-1:0] hold_cnt, hold_n;
    logic [GAP_W-1:0]  gap_cnt, gap_n;
    logic [N-1:0]      gnt_n;
    logic [W-1:0]      gnt_id_n;

    logic [W-1:0] ptr_rel;
    logic [W-1:0] pick_ptr;
    logic         pick_found;
    logic [W-1:0] pick_idx;
    logic [N-1:0] pick_onehot;
    logic         release_now;
    logic         try_grant;

    // Pointer after a release: the owner just served drops to lowest priority.
    assign ptr_rel = (gnt_id == W'(N - 1)) ? '0 : gnt_id + 1'b1;

    assign release_now = !req[gnt_id] ||
                         ((MAX_HOLD != 0) && (hold_cnt == HOLD_LAST) && !lock);

    // A back-to-back handover must already see the rotated pointer.
    assign pick_ptr = (state == GNT) ? ptr_rel : ptr;

    ivl_uvm_rr_pick #(.N(N), .W(W)) u_pick (
        .req   (req),
        .ptr   (pick_ptr),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        pick_onehot           = '0;
        pick_onehot[pick_idx] = 1'b1;
    end

    always_comb begin
        state_n   = state;
        ptr_n     = ptr;
        hold_n    = hold_cnt;
        gap_n     = gap_cnt;
        gnt_n     = gnt;
        gnt_id_n  = gnt_id;
        try_grant = 1'b0;

        case (state)
            IDLE: try_grant = 1'b1;
            GAP: begin
                // The final gap cycle doubles as the arbitration cycle.
                if (gap_cnt == GAP_LAST) try_grant = 1'b1;
                else                     gap_n = gap_cnt + 1'b1;
            end
            GNT: begin
                if (hold_cnt != HOLD_SAT) hold_n = hold_cnt + 1'b1;
                if (release_now) begin
                    ptr_n = ptr_rel;
                    if (GAP_CYCLES > 0) begin
                        state_n = GAP;
                        gap_n   = '0;
                        gnt_n   = '0;
                    end else begin
                        try_grant = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase

        if (try_grant) begin
            if (enable && pick_found) begin
                state_n  = GNT;
                gnt_n    = pick_onehot;
                gnt_id_n = pick_idx;
                hold_n   = '0;
            end else begin
                state_n = IDLE;
                gnt_n   = '0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gap_cnt   <= '0;
            gnt       <= '0;
            gnt_valid <= 1'b0;
            gnt_id    <= '0;
        end else begin
            state     <= state_n;
            ptr       <= ptr_n;
            hold_cnt  <= hold_n;
            gap_cnt   <= gap_n;
            gnt       <= gnt_n;
            gnt_valid <= |gnt_n;
            gnt_id    <= gnt_id_n;
        end
    end

endmodule
